// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one serial divider among NUM_REQ requesters; accept pulse is combinational in IDLE.
// Latency 4 cycles + divider latency (2 for divide-by-zero); requests stay pending in valid while a job is in flight.
module divider_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 24,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic [NUM_REQ-1:0]       resp_valid_out,
  output logic [WIDTH-1:0]         resp_quotient_out,
  output logic [WIDTH-1:0]         resp_remainder_out,
  output logic                     resp_error_out,
  output logic [WIDTH-1:0]         div_dividend_out,
  output logic [WIDTH-1:0]         div_divisor_out,
  output logic                     div_valid_out,
  input  logic [WIDTH-1:0]         div_quotient_in,
  input  logic [WIDTH-1:0]         div_remainder_in,
  input  logic                     div_valid_in,
  input  logic                     div_error_in,
  input  logic                     div_busy_in
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr, gnt_idx, gnt_q, rr_next;
  logic [IDX_W:0]     scan_idx, inc_idx;
  logic               gnt_found;
  logic [WIDTH-1:0]   sel_dividend, sel_divisor;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [WIDTH-1:0]   pend_quo, pend_rem;
  logic               pend_err;

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
      if (scan_idx >= NUM_REQ_W) scan_idx = scan_idx - NUM_REQ_W;
      if (!gnt_found && req_valid_in[scan_idx[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[IDX_W-1:0];
      end
    end
    sel_dividend = req_dividend_in[gnt_idx*WIDTH +: WIDTH];
    sel_divisor  = req_divisor_in[gnt_idx*WIDTH +: WIDTH];
    inc_idx      = {1'b0, gnt_q} + (IDX_W + 1)'(1);
    rr_next      = (inc_idx >= NUM_REQ_W) ? '0 : inc_idx[IDX_W-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req_ready_out = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found && !rst_in) begin
          req_ready_out[gnt_idx] = 1'b1;
          state_d = (sel_divisor == '0) ? RESPOND : ISSUE;
        end
      end
      ISSUE:   if (!div_busy_in) state_d = WAIT;
      WAIT:    if (div_valid_in || tmo_cnt == CNT_LAST) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr             <= '0;
      gnt_q              <= '0;
      tmo_cnt            <= '0;
      pend_quo           <= '0;
      pend_rem           <= '0;
      pend_err           <= 1'b0;
      div_dividend_out   <= '0;
      div_divisor_out    <= '0;
      div_valid_out      <= 1'b0;
      resp_valid_out     <= '0;
      resp_quotient_out  <= '0;
      resp_remainder_out <= '0;
      resp_error_out     <= 1'b0;
    end else begin
      div_valid_out  <= 1'b0;
      resp_valid_out <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            gnt_q            <= gnt_idx;
            div_dividend_out <= sel_dividend;
            div_divisor_out  <= sel_divisor;
            // Divide-by-zero is answered locally; the divider never sees it.
            if (sel_divisor == '0) begin
              pend_quo <= '0;
              pend_rem <= sel_dividend;
              pend_err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!div_busy_in) begin
            div_valid_out <= 1'b1;
            tmo_cnt       <= '0;
          end
        end
        WAIT: begin
          if (div_valid_in) begin
            pend_quo <= div_quotient_in;
            pend_rem <= div_remainder_in;
            pend_err <= div_error_in;
          end else if (tmo_cnt == CNT_LAST) begin
            pend_quo <= '1;
            pend_rem <= '0;
            pend_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        RESPOND: begin
          resp_valid_out[gnt_q] <= 1'b1;
          resp_quotient_out     <= pend_quo;
          resp_remainder_out    <= pend_rem;
          resp_error_out        <= pend_err;
          rr_ptr                <= rr_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one serial `divider` instance among NUM_REQ requesters, e.g. per-voice normalisers and the mix output normaliser.
- Each requester presents a dividend/divisor pair with a valid/ready handshake.
- The arbiter grants round-robin, issues the job to the divider, waits for the result and returns it to the granted requester with a one-cycle response pulse.
- It sits between the mixer/normalisation logic and the single shared divider.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 24, operand and result width in bits; must match the divider's WIDTH.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for the divider result before forcing an error response.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- req_valid_in  input  NUM_REQ  per-requester job request
- req_dividend_in  input  NUM_REQ*WIDTH  packed dividends; requester i uses slice [i*WIDTH +: WIDTH]
- req_divisor_in  input  NUM_REQ*WIDTH  packed divisors, same packing
- req_ready_out  output  NUM_REQ  one-hot accept pulse
- resp_valid_out  output  NUM_REQ  one-hot result pulse
- resp_quotient_out  output  WIDTH  result quotient, shared by all requesters
- resp_remainder_out  output  WIDTH  result remainder
- resp_error_out  output  1  divide-by-zero or timeout
- div_dividend_out  output  WIDTH  to divider dividend_in
- div_divisor_out  output  WIDTH  to divider divisor_in
- div_valid_out  output  1  to divider data_valid_in
- div_quotient_in  input  WIDTH  from divider quotient_out
- div_remainder_in  input  WIDTH  from divider remainder_out
- div_valid_in  input  1  from divider data_valid_out
- div_error_in  input  1  from divider error_out
- div_busy_in  input  1  from divider busy_out

Behaviour:
- Clock and reset: single clock clk_in; reset rst_in is synchronous and active-high.
- Reset state: all outputs 0, state IDLE, rr_ptr=0, timeout counter 0.
- Reset mid-operation abandons the job; no response is issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any req_valid_in is high, grant g = first set index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Assert req_ready_out[g] for exactly that cycle; latch g, the dividend and the divisor.
  - If the latched divisor is 0, go to RESPOND with error=1, quotient=0, remainder=dividend; the divider is not used.
  - Otherwise go to ISSUE.
- ISSUE:
  - While div_busy_in=1, hold with div_valid_out=0.
  - Once div_busy_in=0, drive div_valid_out=1 for exactly one cycle with the latched operands, clear the timeout counter, and go to WAIT.
- div_dividend_out and div_divisor_out hold the latched operands at all times; they are 0 after reset.
- WAIT:
  - On div_valid_in=1, capture quotient, remainder and div_error_in, then go to RESPOND.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES-1 without div_valid_in, go to RESPOND with error=1, quotient all ones, remainder 0.
- RESPOND:
  - Assert resp_valid_out[g]=1 for one cycle.
  - resp_quotient_out, resp_remainder_out and resp_error_out are valid in that cycle and hold their values until the next response.
  - Set rr_ptr=(g+1) mod NUM_REQ and go to IDLE.
- Stray signals:
  - div_valid_in outside WAIT is ignored.
  - A late result after a timeout is ignored.
- Handshake rules:
  - A requester keeps req_valid_in and its operands stable until it sees its req_ready_out pulse. Operands are sampled on that pulse, so later changes are harmless.
  - A requester may re-request in the cycle after its resp_valid_out pulse.
- Simultaneous requests: only one grant per IDLE visit. Every waiting requester is served within NUM_REQ jobs (no starvation).
- Timing:
  - Minimum turnaround with an idle divider is 4 cycles plus divider latency.
  - Divide-by-zero turnaround is 2 cycles.
- At most one job is outstanding in the divider at any time.

Test Plan:
- Single request, NUM_REQ=4: req0 dividend=1000, divisor=3 -> req_ready_out=0001 for one cycle; one div_valid_out pulse; after the divider result, resp_valid_out=0001 with quotient=333, remainder=1, error=0.
- All four requesters request continuously from reset -> grant order 0,1,2,3,0. Each gets exactly one resp_valid pulse per round, and the correct quotient for its own operands (e.g. 100/1, 100/2, 100/3, 100/4 -> 100, 50, 33, 25).
- req2 divisor=0, dividend=77 -> divider is never pulsed; resp_valid_out=0100 two cycles after accept with error=1, quotient=0, remainder=77; rr_ptr advances to 3.
- Divider model withholds div_valid_in -> after TIMEOUT_CYCLES=64 cycles in WAIT, the response has error=1 and quotient=0xFFFFFF. A late div_valid_in afterwards produces no extra resp_valid.
- div_busy_in held high for 10 cycles at ISSUE -> div_valid_out stays 0, then pulses exactly once after busy drops.
- Assert rst_in for one cycle during WAIT -> all outputs 0 next cycle and no response for the abandoned job. After release, a new req1 request is granted first (rr_ptr=0 scan, req0 idle).
